// File: rtl/imm_sequencer.sv
// imm_sequencer: hardwired control FSM for instruction fetch and the immediate
// ALU class (addi, andi, ori). Emits one registered control vector per clock,
// with run/stop, memory wait states, an illegal-opcode trap and a watchdog.
module imm_sequencer #(
  parameter int             OPW     = 5,
  parameter int             OP_LSB  = 27,
  parameter logic [OPW-1:0] OP_ADDI = 5'b01100,
  parameter logic [OPW-1:0] OP_ANDI = 5'b01101,
  parameter logic [OPW-1:0] OP_ORI  = 5'b01110,
  parameter int             TO_W    = 4,
  parameter int             CNT_W   = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [20:0]      ctrl,
  output logic [3:0]       step,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  // Control strobe bit positions
  localparam int PC_OUT    = 0;
  localparam int ZLOW_OUT  = 1;
  localparam int MDR_OUT   = 2;
  localparam int MAR_IN    = 3;
  localparam int ZLOW_IN   = 4;
  localparam int PC_IN     = 5;
  localparam int MDR_IN    = 6;
  localparam int IR_IN     = 7;
  localparam int Y_IN      = 8;
  localparam int INC_PC    = 9;
  localparam int READ      = 10;
  localparam int MD_READ   = 11;
  localparam int GRA       = 12;
  localparam int GRB       = 13;
  localparam int R_IN      = 14;
  localparam int R_OUT     = 15;
  localparam int BA_OUT    = 16;
  localparam int CSIGN_OUT = 17;
  localparam int ALU_ADD   = 18;
  localparam int ALU_AND   = 19;
  localparam int ALU_OR    = 20;

  // Last watchdog value before the increment that reaches all-ones
  localparam logic [TO_W-1:0] WD_LAST = {TO_W{1'b1}} - 1'b1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    OPC_ADD = 2'd0,
    OPC_AND = 2'd1,
    OPC_OR  = 2'd2
  } opc_t;

  state_t           state_q, state_d;
  opc_t             opc_q, opc_d;
  logic [20:0]      ctrl_q, ctrl_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OPW-1:0]   opcode;

  // Only the opcode field of ir matters; the rest is deliberately ignored
  logic unused_ir;
  assign unused_ir = ^ir;
  assign opcode    = ir[OP_LSB +: OPW];

  // State, strobe vector, decoded class, watchdog, flags and counter registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      opc_q     <= OPC_ADD;
      ctrl_q    <= '0;
      wd_q      <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      ctrl_q    <= ctrl_d;
      wd_q      <= wd_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

  // Next state, then the strobes of that next state so ctrl is registered
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    wd_d      = wd_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    count_d   = count_q;
    ctrl_d    = '0;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wd_d    = '0;
      end
      S_T1: begin
        if (mem_ready) begin
          state_d = S_T2;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_q == WD_LAST) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (opcode == OP_ADDI) begin
          opc_d   = OPC_ADD;
          state_d = S_T4;
        end else if (opcode == OP_ANDI) begin
          opc_d   = OPC_AND;
          state_d = S_T4;
        end else if (opcode == OP_ORI) begin
          opc_d   = OPC_OR;
          state_d = S_T4;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = S_T6;
      S_T6: begin
        count_d = count_q + 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    unique case (state_d)
      S_T0: begin
        ctrl_d[PC_OUT]  = 1'b1;
        ctrl_d[MAR_IN]  = 1'b1;
        ctrl_d[INC_PC]  = 1'b1;
        ctrl_d[ZLOW_IN] = 1'b1;
      end
      S_T1: begin
        ctrl_d[ZLOW_OUT] = 1'b1;
        ctrl_d[READ]     = 1'b1;
        ctrl_d[MD_READ]  = 1'b1;
        ctrl_d[MDR_IN]   = 1'b1;
        // PC loads only on the first T1 cycle, not on wait cycles
        ctrl_d[PC_IN]    = (state_q != S_T1);
      end
      S_T2: begin
        ctrl_d[MDR_OUT] = 1'b1;
        ctrl_d[IR_IN]   = 1'b1;
      end
      S_T4: begin
        ctrl_d[GRB]    = 1'b1;
        ctrl_d[Y_IN]   = 1'b1;
        ctrl_d[BA_OUT] = (opc_d == OPC_ADD);
        ctrl_d[R_OUT]  = (opc_d != OPC_ADD);
      end
      S_T5: begin
        ctrl_d[CSIGN_OUT] = 1'b1;
        ctrl_d[ZLOW_IN]   = 1'b1;
        ctrl_d[ALU_ADD]   = (opc_d == OPC_ADD);
        ctrl_d[ALU_AND]   = (opc_d == OPC_AND);
        ctrl_d[ALU_OR]    = (opc_d == OPC_OR);
      end
      S_T6: begin
        ctrl_d[ZLOW_OUT] = 1'b1;
        ctrl_d[GRA]      = 1'b1;
        ctrl_d[R_IN]     = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign ctrl        = ctrl_q;
  assign step        = state_q;
  assign illegal     = illegal_q;
  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_imm_sequencer.sv
// tb_imm_sequencer: randomized scoreboard bench for imm_sequencer. The driver
// plans each instruction's cycle sequence from opcode and wait count and queues
// the expected outputs; the monitor pops and compares once per cycle.
module tb_imm_sequencer;

  localparam int CNT_W = 6;

  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;

  // Expected strobe vectors
  localparam logic [20:0] C_T0    = 21'h000219; // PCout MARin Zlowin IncPC
  localparam logic [20:0] C_T1F   = 21'h000C62; // Zlowout PCin MDRin Read MD_read
  localparam logic [20:0] C_T1W   = 21'h000C42; // same without PCin
  localparam logic [20:0] C_T2    = 21'h000084; // MDRout IRin
  localparam logic [20:0] C_T4A   = 21'h012100; // Grb Yin BAout
  localparam logic [20:0] C_T4L   = 21'h00A100; // Grb Yin Rout
  localparam logic [20:0] C_T5ADD = 21'h060010; // Csignout Zlowin ADD
  localparam logic [20:0] C_T5AND = 21'h0A0010; // Csignout Zlowin AND
  localparam logic [20:0] C_T5OR  = 21'h120010; // Csignout Zlowin OR
  localparam logic [20:0] C_T6    = 21'h005002; // Zlowout Gra Rin

  logic             clock;
  logic             clear;
  logic             run;
  logic [31:0]      ir;
  logic             mem_ready;
  logic [20:0]      ctrl;
  logic [3:0]       step;
  logic             illegal;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  imm_sequencer #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .clear      (clear),
    .run        (run),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .ctrl       (ctrl),
    .step       (step),
    .illegal    (illegal),
    .fault      (fault),
    .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]       st;
    logic [20:0]      cv;
    logic             ill;
    logic             flt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic             m_illegal;
  logic             m_fault;
  logic [CNT_W-1:0] m_count;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("step", 32'(step), 32'(e.st));
      chk("ctrl", 32'(ctrl), 32'(e.cv));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("fault", 32'(fault), 32'(e.flt));
      chk("instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  // Drive inputs for one edge and queue the state expected after it
  task automatic tick(input logic r, input logic mr, input logic [31:0] irv,
                      input logic [3:0] st, input logic [20:0] cv);
    exp_t e;
    run       = r;
    mem_ready = mr;
    ir        = irv;
    @(posedge clock);
    e.st  = st;
    e.cv  = cv;
    e.ill = m_illegal;
    e.flt = m_fault;
    e.cnt = m_count;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    clear = 1'b0;
    #1;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    m_illegal = 1'b0;
    m_fault   = 1'b0;
    m_count   = '0;
    @(posedge clock);
    #1;
    clear = 1'b1;
    tick(1'b0, rb(), $urandom, 4'd0, '0);
  endtask

  // Current cycle is T0. res: 0 = back in T0, 1 = IDLE, 2 = HALT
  task automatic do_instr(input logic [4:0] op, input int waits, input logic run_next,
                          input bit abort5, output int res);
    logic [31:0] irv;
    tick(rb(), rb(), $urandom, 4'd2, C_T1F);
    for (int w = 0; w < waits; w++) begin
      if (w == 14) begin
        m_fault = 1'b1;
        tick(rb(), 1'b0, $urandom, 4'd15, '0);
        res = 2;
        return;
      end
      tick(rb(), 1'b0, $urandom, 4'd2, C_T1W);
    end
    tick(rb(), 1'b1, $urandom, 4'd3, C_T2);
    tick(rb(), rb(), $urandom, 4'd4, '0);
    irv = {op, 27'($urandom)};
    if (!is_legal(op)) begin
      m_illegal = 1'b1;
      tick(rb(), rb(), irv, 4'd15, '0);
      res = 2;
      return;
    end
    tick(rb(), rb(), irv, 4'd5, (op == OP_ADDI) ? C_T4A : C_T4L);
    tick(rb(), rb(), $urandom, 4'd6,
         (op == OP_ADDI) ? C_T5ADD : ((op == OP_ANDI) ? C_T5AND : C_T5OR));
    if (abort5) begin
      #2;
      exp_q.delete();
      clear = 1'b0;
      #1;
      chk("abort_ctrl", 32'(ctrl), 32'd0);
      chk("abort_step", 32'(step), 32'd0);
      chk("abort_count", 32'(instr_count), 32'd0);
      m_illegal = 1'b0;
      m_fault   = 1'b0;
      m_count   = '0;
      @(posedge clock);
      #1;
      clear = 1'b1;
      res = 1;
      return;
    end
    tick(rb(), rb(), $urandom, 4'd7, C_T6);
    m_count = m_count + 1'b1;
    if (run_next) begin
      tick(1'b1, rb(), $urandom, 4'd1, C_T0);
      res = 0;
    end else begin
      tick(1'b0, rb(), $urandom, 4'd0, '0);
      res = 1;
    end
  endtask

  task automatic enter();
    tick(1'b1, rb(), $urandom, 4'd1, C_T0);
  endtask

  initial begin
    int res;
    int n;
    logic [4:0] op;
    logic [4:0] legal_ops [3];
    legal_ops[0] = OP_ADDI;
    legal_ops[1] = OP_ANDI;
    legal_ops[2] = OP_ORI;
    m_illegal = 1'b0;
    m_fault   = 1'b0;
    m_count   = '0;
    clear     = 1'b0;
    run       = 1'b1;
    mem_ready = 1'b1;
    ir        = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("init_step", 32'(step), 32'd0);
    chk("init_ctrl", 32'(ctrl), 32'd0);
    chk("init_illegal", 32'(illegal), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    chk("init_count", 32'(instr_count), 32'd0);
    clear = 1'b1;
    tick(1'b0, 1'b1, $urandom, 4'd0, '0);
    tick(1'b0, 1'b0, $urandom, 4'd0, '0);

    // andi, no wait
    enter();
    do_instr(OP_ANDI, 0, 1'b0, 1'b0, res);
    // addi, three wait cycles
    enter();
    do_instr(OP_ADDI, 3, 1'b0, 1'b0, res);
    // ori three times back to back, run dropped for the last
    enter();
    do_instr(OP_ORI, 0, 1'b1, 1'b0, res);
    do_instr(OP_ORI, 0, 1'b1, 1'b0, res);
    do_instr(OP_ORI, 0, 1'b0, 1'b0, res);
    tick(1'b0, rb(), $urandom, 4'd0, '0);

    // Random legal mix
    res = 1;
    for (int i = 0; i < 20; i++) begin
      if (res == 1) enter();
      op = legal_ops[$urandom_range(0, 2)];
      do_instr(op, $urandom_range(0, 5), rb(), 1'b0, res);
    end

    // Run up to and across the counter wrap
    n = (1 << CNT_W) - int'(m_count);
    for (int i = 0; i < n; i++) begin
      if (res == 1) enter();
      do_instr(legal_ops[$urandom_range(0, 2)], $urandom_range(0, 2),
               (i != n - 1), 1'b0, res);
    end
    chk("wrap_count", 32'(instr_count), 32'd0);
    chk("wrap_flags", 32'({illegal, fault}), 32'd0);

    // Reset in the middle of T5
    enter();
    do_instr(OP_ANDI, 1, 1'b1, 1'b1, res);
    tick(1'b0, rb(), $urandom, 4'd0, '0);
    tick(1'b0, rb(), $urandom, 4'd0, '0);

    // Illegal opcode 11111 traps into HALT
    enter();
    do_instr(5'b11111, 0, 1'b1, 1'b0, res);
    repeat (5) tick(rb(), rb(), $urandom, 4'd15, '0);
    do_reset();

    // Random illegal opcodes
    for (int i = 0; i < 3; i++) begin
      do op = 5'($urandom); while (is_legal(op));
      enter();
      do_instr(op, $urandom_range(0, 3), 1'b1, 1'b0, res);
      repeat (3) tick(rb(), rb(), $urandom, 4'd15, '0);
      do_reset();
    end

    // Watchdog: memory never ready
    enter();
    do_instr(OP_ADDI, 40, 1'b1, 1'b0, res);
    repeat (4) tick(rb(), rb(), $urandom, 4'd15, '0);
    do_reset();

    // Fourteen waits is one short of the watchdog
    enter();
    do_instr(OP_ORI, 14, 1'b0, 1'b0, res);
    tick(1'b0, rb(), $urandom, 4'd0, '0);

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
